dmem_dump_responder: RTL and testbench

DMEM_DUMP_RESPONDER -- requirements
Module: dmem_dump_responder

---
 rtl/dmem_dump_responder.sv | 116 +++++++++++
 tb/tb_dmem_dump_responder.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_dump_responder.sv
// dmem_dump_responder: word-addressed data memory with combinational loads and a
// ready/valid port that streams the whole memory out on a rising edge of dump.
// Optional build macro DMEM_ALIGN_CHECK_EN: misaligned stores are dropped and
// raise the sticky misalign_err flag; without it the low address bits are ignored.
module dmem_dump_responder #(
    parameter int N = 64,
    parameter int DEPTH = 32,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          CLOCK_50,
    input  logic          reset,
    input  logic [N-1:0]  DM_addr,
    input  logic [N-1:0]  DM_writeData,
    input  logic          DM_writeEnable,
    output logic [N-1:0]  DM_readData,
    input  logic          dump,
    output logic          dump_valid,
    input  logic          dump_ready,
    output logic [AW-1:0] dump_idx,
    output logic [N-1:0]  dump_data,
    output logic          dump_done,
    output logic          misalign_err
);
    typedef enum logic [1:0] {IDLE, DUMP, DONE} state_t;

    state_t        state;
    logic [N-1:0]  mem [DEPTH];
    logic [AW-1:0] idx;
    logic [AW-1:0] snap_idx;
    logic [N-1:0]  snap_data;
    logic          wr_ok;
    logic          dump_prev;
    logic          armed;
    logic          unused_addr;

    assign idx = DM_addr[AW+2:3];
    assign unused_addr = ^{DM_addr[N-1:AW+3], DM_addr[2:0]};

`ifdef DMEM_ALIGN_CHECK_EN
    assign wr_ok = DM_writeEnable && DM_addr[2:0] == 3'b000;

    // Sticky flag: any misaligned store attempt is remembered until reset.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset)
            misalign_err <= 1'b0;
        else if (DM_writeEnable && DM_addr[2:0] != 3'b000)
            misalign_err <= 1'b1;
    end
`else
    assign wr_ok = DM_writeEnable;
    assign misalign_err = 1'b0;
`endif

    assign DM_readData = reset ? mem[idx] : '0;

    // The word about to be presented; a store landing on it at the same edge is
    // forwarded so the snapshot never misses it.
    assign snap_idx = (state == IDLE) ? '0 : dump_idx + 1'b1;
    assign snap_data = (wr_ok && idx == snap_idx) ? DM_writeData : mem[snap_idx];

    // Memory array: cleared by reset, at most one word stored per cycle.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (wr_ok) begin
            mem[idx] <= DM_writeData;
        end
    end

    // Dump FSM; armed blocks a start until dump has been seen low after reset,
    // so a request held across reset release does not launch a dump.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            dump_prev  <= 1'b0;
            armed      <= 1'b0;
            dump_valid <= 1'b0;
            dump_done  <= 1'b0;
            dump_idx   <= '0;
            dump_data  <= '0;
        end else begin
            dump_prev <= dump;
            armed     <= armed | ~dump;
            case (state)
                IDLE: begin
                    if (dump && !dump_prev && armed) begin
                        state      <= DUMP;
                        dump_valid <= 1'b1;
                        dump_idx   <= snap_idx;
                        dump_data  <= snap_data;
                    end
                end
                DUMP: begin
                    if (dump_ready) begin
                        if (dump_idx == AW'(DEPTH - 1)) begin
                            state      <= DONE;
                            dump_valid <= 1'b0;
                            dump_done  <= 1'b1;
                        end else begin
                            dump_idx  <= snap_idx;
                            dump_data <= snap_data;
                        end
                    end
                end
                DONE: begin
                    if (!dump) begin
                        state     <= IDLE;
                        dump_done <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_dump_responder.sv
// tb_dmem_dump_responder: randomized bench for dmem_dump_responder with an
// array-based memory model and a per-word snapshot scoreboard for the dump port.
module tb_dmem_dump_responder;
    localparam int N = 64;
    localparam int DEPTH = 32;
    localparam int AW = 5;
`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic          CLOCK_50 = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  DM_addr = '0;
    logic [N-1:0]  DM_writeData = '0;
    logic          DM_writeEnable = 1'b0;
    logic          dump = 1'b0;
    logic          dump_ready = 1'b0;
    logic [N-1:0]  DM_readData;
    logic [N-1:0]  dump_data;
    logic [AW-1:0] dump_idx;
    logic          dump_valid;
    logic          dump_done;
    logic          misalign_err;

    logic [N-1:0]  model_mem [DEPTH];
    bit            model_mis;
    int            compared = 0;
    int            mismatched = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    dmem_dump_responder #(.N(N), .DEPTH(DEPTH)) dut (
        .CLOCK_50(CLOCK_50),
        .reset(reset),
        .DM_addr(DM_addr),
        .DM_writeData(DM_writeData),
        .DM_writeEnable(DM_writeEnable),
        .DM_readData(DM_readData),
        .dump(dump),
        .dump_valid(dump_valid),
        .dump_ready(dump_ready),
        .dump_idx(dump_idx),
        .dump_data(dump_data),
        .dump_done(dump_done),
        .misalign_err(misalign_err)
    );

    // One clock: apply the store rule to the model at the edge, return at negedge.
    task automatic cycle();
        @(posedge CLOCK_50);
        if (reset && DM_writeEnable) begin
            if (!ALIGN || DM_addr[2:0] == 3'b000)
                model_mem[DM_addr[AW+2:3]] = DM_writeData;
            else
                model_mis = 1'b1;
        end
        @(negedge CLOCK_50);
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++)
            model_mem[i] = '0;
        model_mis = 1'b0;
    endtask

    task automatic store(input logic [N-1:0] a, input logic [N-1:0] d);
        DM_addr = a;
        DM_writeData = d;
        DM_writeEnable = 1'b1;
        cycle();
        DM_writeEnable = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge CLOCK_50);
        reset = 1'b0;
        clear_model();
        repeat (2) @(negedge CLOCK_50);
        compared++;
        if (dump_valid !== 1'b0 || dump_done !== 1'b0 || dump_idx !== '0 || dump_data !== '0 || misalign_err !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_outputs: valid=%b done=%b idx=%0d data=%h err=%b expected all zero",
                     dump_valid, dump_done, dump_idx, dump_data, misalign_err);
        end
        for (int i = 0; i < 3; i++) begin
            DM_addr = {$urandom, $urandom};
            #1;
            compared++;
            if (DM_readData !== '0) begin
                mismatched++;
                $display("FAIL reset_read: addr=%h got %h expected 0", DM_addr, DM_readData);
            end
        end
        @(negedge CLOCK_50);
        reset = 1'b1;
        cycle();
    endtask

    task automatic test_store_load();
        logic [N-1:0] a;
        store(64'h10, 64'hDEADBEEF_0000_0001);
        DM_addr = 64'h10;
        #1;
        compared++;
        if (DM_readData !== 64'hDEADBEEF_0000_0001) begin
            mismatched++;
            $display("FAIL load_0x10: got %h expected deadbeef00000001", DM_readData);
        end
        DM_addr = 64'h08;
        #1;
        compared++;
        if (DM_readData !== 64'h0) begin
            mismatched++;
            $display("FAIL load_0x08: got %h expected 0", DM_readData);
        end
        store(64'h100, 64'h5);
        DM_addr = 64'h0;
        #1;
        compared++;
        if (DM_readData !== 64'h5) begin
            mismatched++;
            $display("FAIL wrap_0x100: got %h expected 5", DM_readData);
        end
        for (int i = 0; i < 40; i++) begin
            a = {$urandom, $urandom};
            a[2:0] = 3'b000;
            store(a, {$urandom, $urandom});
            DM_addr = a;
            #1;
            compared++;
            if (DM_readData !== model_mem[a[AW+2:3]]) begin
                mismatched++;
                $display("FAIL load_after_store: addr=%h got %h expected %h", a, DM_readData, model_mem[a[AW+2:3]]);
            end
            DM_addr = {$urandom, $urandom};
            #1;
            compared++;
            if (DM_readData !== model_mem[DM_addr[AW+2:3]]) begin
                mismatched++;
                $display("FAIL random_load: addr=%h got %h expected %h", DM_addr, DM_readData, model_mem[DM_addr[AW+2:3]]);
            end
        end
    endtask

    // mode 0: ready on odd cycles; mode 1: random ready, stores and dump toggling;
    // mode 2: directed stores around the held and upcoming words.
    task automatic test_dump(input int mode);
        int exp_i = 0;
        int cyc = 0;
        int stall = 0;
        logic [N-1:0] held = '0;
        bit have = 1'b0;
        bit rdy;
        for (int i = 0; i < DEPTH; i++)
            store(N'(i * 8), mode == 1 ? {$urandom, $urandom} : N'(i + 1));
        dump = 1'b1;
        dump_ready = 1'b0;
        cycle();
        while (exp_i < DEPTH && cyc < 400) begin
            if (!have) begin
                held = model_mem[exp_i];
                have = 1'b1;
                stall = 0;
            end
            compared++;
            if (dump_valid !== 1'b1 || dump_idx !== AW'(exp_i) || dump_data !== held) begin
                mismatched++;
                $display("FAIL dump%0d_word: valid=%b idx=%0d data=%h expected idx=%0d data=%h",
                         mode, dump_valid, dump_idx, dump_data, exp_i, held);
            end
            if (mode == 2 && stall == 0 && (exp_i == 3 || exp_i == 6 || exp_i == 7)) begin
                compared++;
                if (dump_data !== (exp_i == 3 ? 64'h4 : exp_i == 6 ? 64'hCC : 64'hBB)) begin
                    mismatched++;
                    $display("FAIL dump_store_word%0d: got %h", exp_i, dump_data);
                end
            end
            rdy = mode == 0 ? cyc[0] : mode == 1 ? 1'($urandom_range(0, 1)) : !(exp_i == 3 && stall < 2);
            DM_writeEnable = 1'b0;
            if (mode == 1) begin
                DM_writeEnable = 1'($urandom_range(0, 1));
                DM_addr = {$urandom, $urandom};
                DM_addr[2:0] = 3'b000;
                DM_writeData = {$urandom, $urandom};
                dump = 1'($urandom_range(0, 1));
            end
            if (mode == 2 && exp_i == 3 && stall == 0) begin
                DM_writeEnable = 1'b1; DM_addr = 64'd24; DM_writeData = 64'hAA;
            end
            if (mode == 2 && exp_i == 3 && stall == 1) begin
                DM_writeEnable = 1'b1; DM_addr = 64'd56; DM_writeData = 64'hBB;
            end
            if (mode == 2 && exp_i == 5) begin
                DM_writeEnable = 1'b1; DM_addr = 64'd48; DM_writeData = 64'hCC;
            end
            dump_ready = rdy;
            cycle();
            cyc++;
            stall++;
            if (rdy) begin
                exp_i++;
                have = 1'b0;
            end
        end
        DM_writeEnable = 1'b0;
        dump_ready = 1'b0;
        compared++;
        if (exp_i != DEPTH) begin
            mismatched++;
            $display("FAIL dump%0d_timeout: handshakes=%0d expected %0d", mode, exp_i, DEPTH);
        end
        compared++;
        if (dump_done !== 1'b1 || dump_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL dump%0d_done: done=%b valid=%b expected 1/0", mode, dump_done, dump_valid);
        end
        dump = 1'b1;
        dump_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            compared++;
            if (dump_done !== 1'b1 || dump_valid !== 1'b0) begin
                mismatched++;
                $display("FAIL dump%0d_hold_done: done=%b valid=%b expected 1/0", mode, dump_done, dump_valid);
            end
        end
        dump = 1'b0;
        dump_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cycle();
            compared++;
            if (dump_done !== 1'b0 || dump_valid !== 1'b0) begin
                mismatched++;
                $display("FAIL dump%0d_idle: done=%b valid=%b expected 0/0", mode, dump_done, dump_valid);
            end
        end
    endtask

    task automatic test_reset_mid_dump();
        int n = 0;
        for (int i = 0; i < DEPTH; i++)
            store(N'(i * 8), N'(i + 1));
        dump = 1'b1;
        cycle();
        dump_ready = 1'b1;
        while (dump_idx !== AW'(10) && n < 40) begin
            cycle();
            n++;
        end
        dump_ready = 1'b0;
        compared++;
        if (dump_idx !== AW'(10) || dump_valid !== 1'b1 || dump_data !== 64'd11) begin
            mismatched++;
            $display("FAIL reach_idx10: idx=%0d valid=%b data=%h expected 10/1/b", dump_idx, dump_valid, dump_data);
        end
        reset = 1'b0;
        clear_model();
        DM_addr = 64'h50;
        #1;
        compared++;
        if (dump_valid !== 1'b0 || dump_done !== 1'b0 || dump_idx !== '0 || dump_data !== '0 || DM_readData !== '0) begin
            mismatched++;
            $display("FAIL mid_dump_reset: valid=%b done=%b idx=%0d data=%h read=%h expected all zero",
                     dump_valid, dump_done, dump_idx, dump_data, DM_readData);
        end
        @(negedge CLOCK_50);
        reset = 1'b1;
        dump_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            compared++;
            if (dump_valid !== 1'b0 || dump_done !== 1'b0) begin
                mismatched++;
                $display("FAIL no_restart_after_reset: valid=%b done=%b expected 0/0", dump_valid, dump_done);
            end
        end
        for (int i = 0; i < 4; i++) begin
            DM_addr = {$urandom, $urandom};
            #1;
            compared++;
            if (DM_readData !== model_mem[DM_addr[AW+2:3]]) begin
                mismatched++;
                $display("FAIL cleared_read: addr=%h got %h expected %h", DM_addr, DM_readData, model_mem[DM_addr[AW+2:3]]);
            end
        end
        dump = 1'b0;
        dump_ready = 1'b0;
        cycle();
    endtask

    task automatic test_misalign();
        store(64'h10, 64'h1111);
        store(64'h13, 64'h7);
        DM_addr = 64'h10;
        #1;
        compared++;
        if (DM_readData !== (ALIGN ? 64'h1111 : 64'h7) || DM_readData !== model_mem[2]) begin
            mismatched++;
            $display("FAIL misalign_mem: got %h expected %h", DM_readData, model_mem[2]);
        end
        compared++;
        if (misalign_err !== ALIGN || misalign_err !== model_mis) begin
            mismatched++;
            $display("FAIL misalign_flag: got %b expected %b", misalign_err, model_mis);
        end
        store(64'h18, 64'h9);
        cycle();
        compared++;
        if (misalign_err !== model_mis) begin
            mismatched++;
            $display("FAIL misalign_sticky: got %b expected %b", misalign_err, model_mis);
        end
        DM_addr = 64'h18;
        #1;
        compared++;
        if (DM_readData !== 64'h9) begin
            mismatched++;
            $display("FAIL aligned_after_misalign: got %h expected 9", DM_readData);
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_dump(0);
        test_dump(2);
        test_dump(1);
        test_reset_mid_dump();
        test_misalign();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
